// File: rtl/mem_responder.sv
// mem_responder -- memory-side responder for the pipelined core.
//
// Serves the core's instruction fetch port and data port from flop arrays
// with combinational reads, and hosts a byte-serial loader that fills either
// array over the 8-bit chip IO while the core is held off.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   inst_addr / inst_data  fetch word address in, instruction word out
//   ram_addr / ram_wdata / ram_we / ram_rdata
//                          core data port (word address, store, load data)
//   load_en                loader mode select (also drives core_hold)
//   load_valid / load_byte / load_ready
//                          loader byte stream with ready/valid handshake
//   core_hold              hold request to the core
//
// Build option:
//   MEM_ZERO_ON_RESET_EN   when defined, async reset also clears dmem to 0;
//                          imem always keeps its contents across reset.
//
// Loader stream: header byte {tgt, idx[6:0]} (tgt 0 = imem, 1 = dmem), then
// 4 bytes per word, little-endian. Each word commits in a one-cycle COMMIT
// state, after which idx advances and the next word starts.
module mem_responder #(
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  inst_addr,
  output logic [31:0] inst_data,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_wdata,
  input  logic        ram_we,
  output logic [31:0] ram_rdata,
  input  logic        load_en,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_ready,
  output logic        core_hold
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BYTE, S_COMMIT} state_e;

  state_e          state_q, state_d;
  logic            tgt_q, tgt_d;
  logic [7:0]      idx_q, idx_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0][7:0] asm_q, asm_d;
  logic            ld_wr;

  logic [31:0] imem_q [IMEM_DEPTH];
  logic [31:0] dmem_q [DMEM_DEPTH];

  logic            inst_in_range, ram_in_range;
  logic            imem_we, dmem_we;
  logic [IAW-1:0]  imem_widx;
  logic [DAW-1:0]  dmem_widx;
  logic [31:0]     dmem_wdata;

  // ---------------------------------------------------------------- reads
  assign inst_in_range = {24'b0, inst_addr} < 32'(IMEM_DEPTH);
  assign ram_in_range  = ram_addr < 32'(DMEM_DEPTH);

  assign inst_data = inst_in_range ? imem_q[inst_addr[IAW-1:0]] : 32'h0;
  assign ram_rdata = ram_in_range  ? dmem_q[ram_addr[DAW-1:0]]  : 32'h0;

  assign core_hold = load_en;

  // ---------------------------------------------------------------- loader
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    load_ready = 1'b0;
    ld_wr      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_en) state_d = S_HDR;
      end
      S_HDR: begin
        load_ready = 1'b1;
        if (load_valid) begin
          tgt_d   = load_byte[7];
          idx_d   = {1'b0, load_byte[6:0]};
          cnt_d   = 2'd0;
          state_d = S_BYTE;
        end
      end
      S_BYTE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          asm_d[cnt_q] = load_byte;
          if (cnt_q == 2'd3) state_d = S_COMMIT;
          else               cnt_d   = cnt_q + 2'd1;
        end
      end
      S_COMMIT: begin
        ld_wr   = 1'b1;
        idx_d   = idx_q + 8'd1;
        cnt_d   = 2'd0;
        state_d = S_BYTE;
      end
      default: state_d = S_IDLE;
    endcase
    // Dropping load_en aborts from any state; the commit is also gated so a
    // loader write can never coincide with an unblocked core store.
    if (!load_en) begin
      state_d = S_IDLE;
      ld_wr   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tgt_q   <= 1'b0;
      idx_q   <= 8'd0;
      cnt_q   <= 2'd0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  // ---------------------------------------------------------------- writes
  // Core stores are blocked while load_en is high and the loader only
  // commits while load_en is high, so the dmem port is never contended.
  always_comb begin
    imem_we    = ld_wr & ~tgt_q;
    imem_widx  = idx_q[IAW-1:0];
    dmem_we    = 1'b0;
    dmem_widx  = ram_addr[DAW-1:0];
    dmem_wdata = ram_wdata;
    if (ld_wr && tgt_q) begin
      dmem_we    = 1'b1;
      dmem_widx  = idx_q[DAW-1:0];
      dmem_wdata = asm_q;
    end else if (ram_we && ram_in_range && !load_en) begin
      dmem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we) imem_q[imem_widx] <= asm_q;
  end

`ifdef MEM_ZERO_ON_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= 32'h0;
    end else if (dmem_we) begin
      dmem_q[dmem_widx] <= dmem_wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (dmem_we) dmem_q[dmem_widx] <= dmem_wdata;
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: fixed read table, hand sequences for loader and
// core-port corner cases, then randomized traffic checked against a simple
// array model of both memories.
module tb_mem_responder;

  localparam int ID = 16;
  localparam int DD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  inst_addr;
  logic [31:0] inst_data;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;
  logic        load_en, load_valid, load_ready, core_hold;
  logic [7:0]  load_byte;

  mem_responder #(.IMEM_DEPTH(ID), .DMEM_DEPTH(DD)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_addr(inst_addr), .inst_data(inst_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .load_en(load_en), .load_valid(load_valid), .load_byte(load_byte),
    .load_ready(load_ready), .core_hold(core_hold)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] im_m [ID];
  logic [31:0] dm_m [DD];
  logic [31:0] wq [$];

  typedef struct {
    logic [7:0]  ia;
    logic [31:0] ra;
    logic [31:0] ei;
    logic [31:0] ed;
  } rvec_t;
  rvec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_i(input logic [7:0] a);
    return (a < ID) ? im_m[a[3:0]] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_d(input logic [31:0] a);
    return (a < DD) ? dm_m[a[3:0]] : 32'h0;
  endfunction

  // Present one byte after `gap` idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      load_valid = 1'b0;
      load_byte  = 8'($urandom);
      step();
    end
    load_valid = 1'b1;
    load_byte  = b;
    t = 0;
    while (!load_ready && t < 20) begin
      step();
      t++;
    end
    if (t >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL load_ready_timeout: got 0 expected 1");
    end
    step();
    load_valid = 1'b0;
  endtask

  // Stream header + every word in wq; gmode 0 = back-to-back, 1 = one idle
  // cycle before each data byte, 2 = random idle cycles.
  task automatic load_words(input logic tgt, input logic [6:0] idx, input int gmode);
    int g;
    logic [31:0] wd;
    load_en = 1'b1;
    step();
    send_byte({tgt, idx}, 0);
    foreach (wq[w]) begin
      wd = wq[w];
      for (int b = 0; b < 4; b++) begin
        g = (gmode == 1) ? 1 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
        send_byte(wd[8*b +: 8], g);
      end
      if (tgt) dm_m[(int'(idx) + w) % DD] = wd;
      else     im_m[(int'(idx) + w) % ID] = wd;
    end
    step();            // last word commits here
    ram_we  = 1'b0;
    load_en = 1'b0;
    step();
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      inst_addr = 8'(i);
      ram_addr  = 32'(i);
      #1;
      chk({tag, "_imem"}, inst_data, im_m[i]);
      chk({tag, "_dmem"}, ram_rdata, dm_m[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inst_addr = '0; ram_addr = '0; ram_wdata = '0; ram_we = 1'b0;
    load_en = 1'b0; load_valid = 1'b0; load_byte = '0;
    step();
    step();
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd0);
    rst_n = 1'b1;
    step();

    // Fill both memories with a known pattern.
    wq.delete();
    for (int i = 0; i < ID; i++) wq.push_back(32'h0102_0300 + 32'(i));
    load_words(1'b0, 7'd0, 0);
    for (int i = 0; i < DD; i++) begin
      ram_we = 1'b1; ram_addr = 32'(i); ram_wdata = 32'hD000_0000 + 32'(i);
      step();
      dm_m[i] = ram_wdata;
    end
    ram_we = 1'b0;

    // Read table incl. out-of-range indices.
    tbl[0] = '{8'h03, 32'h0000_0005, 32'h0102_0303, 32'hD000_0005};
    tbl[1] = '{8'h0F, 32'h0000_000F, 32'h0102_030F, 32'hD000_000F};
    tbl[2] = '{8'h00, 32'h0000_0000, 32'h0102_0300, 32'hD000_0000};
    tbl[3] = '{8'h10, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000};
    tbl[4] = '{8'hFF, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000};
    tbl[5] = '{8'h08, 32'hFFFF_FFFF, 32'h0102_0308, 32'h0000_0000};
    tbl[6] = '{8'h07, 32'h8000_0001, 32'h0102_0307, 32'h0000_0000};
    tbl[7] = '{8'h11, 32'h0000_000E, 32'h0000_0000, 32'hD000_000E};
    for (int i = 0; i < 8; i++) begin
      inst_addr = tbl[i].ia;
      ram_addr  = tbl[i].ra;
      #1;
      chk("tbl_inst", inst_data, tbl[i].ei);
      chk("tbl_ram", ram_rdata, tbl[i].ed);
    end

    // imem load: header 02, bytes 13 00 50 00 with valid held high.
    load_en = 1'b1;
    step();
    send_byte(8'h02, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    chk("commit_ready_low", 32'(load_ready), 32'd0);
    chk("commit_hold", 32'(core_hold), 32'd1);
    step();
    chk("after_commit_ready", 32'(load_ready), 32'd1);
    inst_addr = 8'd2;
    #1;
    chk("imem_load", inst_data, 32'h0050_0013);
    im_m[2] = 32'h0050_0013;
    load_en = 1'b0;
    step();
    chk("exit_ready", 32'(load_ready), 32'd0);
    chk("exit_hold", 32'(core_hold), 32'd0);

    // dmem load with wrap from index 15.
    wq.delete();
    wq.push_back(32'hAAAA_0001);
    wq.push_back(32'h0000_BEEF);
    load_words(1'b1, 7'h0F, 0);
    ram_addr = 32'd15; #1;
    chk("wrap_15", ram_rdata, 32'hAAAA_0001);
    ram_addr = 32'd0; #1;
    chk("wrap_0", ram_rdata, 32'h0000_BEEF);

    // Core store: old value same cycle, new value next cycle.
    ram_we = 1'b1; ram_addr = 32'd5; ram_wdata = 32'hDEAD_BEEF;
    #1;
    chk("store_old", ram_rdata, dm_m[5]);
    step();
    ram_we = 1'b0;
    dm_m[5] = 32'hDEAD_BEEF;
    chk("store_new", ram_rdata, 32'hDEAD_BEEF);

    // Out-of-range store and fetch.
    ram_we = 1'b1; ram_addr = 32'h20; ram_wdata = 32'h1234;
    #1;
    chk("oor_rdata", ram_rdata, 32'h0);
    step();
    ram_we = 1'b0;
    inst_addr = 8'hFF; #1;
    chk("oor_inst", inst_data, 32'h0);
    sweep("oor_sweep");

    // Abort after two data bytes.
    load_en = 1'b1;
    step();
    send_byte(8'h83, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    load_en = 1'b0;
    step();
    chk("abort_ready", 32'(load_ready), 32'd0);
    ram_addr = 32'd3; #1;
    chk("abort_word", ram_rdata, dm_m[3]);
    load_en = 1'b1; #1;
    chk("abort_idle", 32'(load_ready), 32'd0);
    step();
    chk("abort_hdr", 32'(load_ready), 32'd1);
    load_en = 1'b0;
    step();

    // Reset mid-word with load_en still asserted.
    load_en = 1'b1;
    step();
    send_byte(8'h84, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_ready", 32'(load_ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_rel_idle", 32'(load_ready), 32'd0);
    step();
    chk("rst_rel_hdr", 32'(load_ready), 32'd1);
    load_en = 1'b0;
    step();
`ifdef MEM_ZERO_ON_RESET_EN
    for (int i = 0; i < DD; i++) dm_m[i] = 32'h0;
`endif
    sweep("rst_sweep");

    // Backpressure: valid toggles around each byte, junk on load_byte when idle.
    wq.delete();
    wq.push_back(32'hCAFE_F00D);
    load_words(1'b0, 7'd9, 1);
    inst_addr = 8'd9; #1;
    chk("bp_word", inst_data, 32'hCAFE_F00D);

    // Randomized traffic against the model.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        ram_we    = 1'($urandom);
        ram_addr  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 20));
        ram_wdata = $urandom;
        inst_addr = 8'($urandom_range(0, 20));
        #1;
        chk("rnd_inst", inst_data, exp_i(inst_addr));
        chk("rnd_ram", ram_rdata, exp_d(ram_addr));
        step();
        if (ram_we && ram_addr < DD) dm_m[ram_addr[3:0]] = ram_wdata;
        ram_we = 1'b0;
      end else begin
        wq.delete();
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) wq.push_back($urandom);
        // A core store attempted during loading must be blocked.
        ram_we    = 1'($urandom);
        ram_addr  = 32'($urandom_range(0, 15));
        ram_wdata = $urandom;
        load_words(1'($urandom), 7'($urandom), 2);
        ram_addr  = 32'($urandom_range(0, 15));
        inst_addr = 8'($urandom_range(0, 15));
        #1;
        chk("rnd_ld_inst", inst_data, exp_i(inst_addr));
        chk("rnd_ld_ram", ram_rdata, exp_d(ram_addr));
      end
    end
    sweep("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the pipelined core's two memory interfaces.
- Serves the core's instruction fetch port (8-bit word address in, 32-bit instruction out) and data port (32-bit address/write data/write strobe in, 32-bit read data out) from flop-based arrays.
- Includes a byte-serial loader FSM on the 8-bit chip IO. The loader fills either memory while the core is held off.

Parameters:
- IMEM_DEPTH, 16, instruction memory depth in 32-bit words; power of 2, 2..256.
- DMEM_DEPTH, 16, data memory depth in 32-bit words; power of 2, 2..128.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- inst_addr  in  8  core fetch word address
- inst_data  out  32  instruction word for inst_addr
- ram_addr  in  32  core data word address
- ram_wdata  in  32  core store data
- ram_we  in  1  core store strobe
- ram_rdata  out  32  load data for ram_addr
- load_en  in  1  loader mode select
- load_valid  in  1  loader byte valid
- load_byte  in  8  loader byte
- load_ready  out  1  loader may accept byte this cycle
- core_hold  out  1  request to hold core in reset/stall

Behaviour:
- Reads are combinational from the arrays: the core samples ram_rdata and inst_data at the same edge it presents the address.
  - In range: inst_data = imem[inst_addr]; ram_rdata = dmem[ram_addr].
  - Out of range (any index bit ≥ log2(DEPTH) set): returns 32'h0.
- Core store: dmem[ram_addr] <= ram_wdata at the rising edge when all of the following hold:
  - ram_we = 1
  - address in range
  - load_en = 0
  - Out-of-range stores are dropped silently.
  - A read of the same address in the same cycle returns the old value.
- Reset:
  - FSM goes to IDLE; byte counter and word index clear to 0.
  - load_ready = 0; core_hold = 0.
  - Array contents are retained (see Optional Feature). Reset may assert mid-word; any partial word is discarded.
- core_hold = load_en (combinational).
- Loader FSM states: IDLE, HDR, BYTE, COMMIT.
  - IDLE: load_ready = 0. load_en = 1 -> HDR next cycle.
  - HDR: load_ready = 1. On load_valid:
    - tgt <= load_byte[7] (0 = imem, 1 = dmem)
    - idx <= load_byte[6:0] (imem index is zero-extended)
    - cnt <= 0
    - -> BYTE
  - BYTE: load_ready = 1. On load_valid, lane cnt of the assembly register <= load_byte. Bytes are little-endian: the first byte is [7:0].
    - cnt < 3: cnt++.
    - cnt = 3: -> COMMIT.
  - COMMIT: load_ready = 0 for exactly one cycle.
    - Writes the word to mem[tgt][idx mod DEPTH]; the index wraps at DEPTH.
    - Then idx++ (wrapping), cnt <= 0, -> BYTE.
  - A byte is transferred only when load_valid & load_ready. load_byte is ignored otherwise.
  - load_en = 0 in any state -> IDLE next cycle; a partial word is discarded and nothing is written.
  - A loader dmem write and a core ram_we never collide: the core store is blocked while load_en = 1.
  - Steady throughput is 5 cycles per word.

Optional Feature:
- Macro: MEM_ZERO_ON_RESET_EN.
- Defined: async reset also clears every dmem word to 0; imem is still retained.
- Undefined: both arrays keep their contents across reset, and dmem has no reset.

Test Plan:
- Load imem:
  - Stimulus: load_en = 1; header 8'h02; bytes 13,00,50,00 with load_valid held high.
  - Response: load_ready drops 1 cycle after the 4th byte; then inst_addr = 2 gives inst_data = 32'h00500013; core_hold = 1 throughout.
- Load dmem with wrap:
  - Stimulus: DMEM_DEPTH = 16; header 8'h8F; words 32'hAAAA0001 then 32'h0000BEEF.
  - Response: ram_addr = 15 reads 32'hAAAA0001; ram_addr = 0 reads 32'h0000BEEF.
- Core store/load:
  - Stimulus: load_en = 0; ram_we = 1, ram_addr = 5, ram_wdata = 32'hDEADBEEF for 1 cycle.
  - Response: in the same cycle ram_rdata shows the old value; in the next cycle it reads 32'hDEADBEEF.
- Out-of-range access:
  - Stimulus: ram_we = 1, ram_addr = 32'h20, data 32'h1234.
  - Response: no dmem word changes, ram_rdata = 0.
  - Stimulus: inst_addr = 8'hFF.
  - Response: inst_data = 0.
- Abort and reset:
  - Stimulus: load_en dropped after 2 data bytes.
  - Response: target word unchanged; FSM is in IDLE with load_ready = 0 next cycle.
  - Stimulus: rst_n pulsed low mid-word.
  - Response: same result, and stored words are retained (or dmem is all zero with MEM_ZERO_ON_RESET_EN).
- Backpressure:
  - Stimulus: load_valid toggled 1,0,1,0 across a word.
  - Response: only valid cycles are counted; the word is assembled correctly.
